// File: rtl/rof_stream_ctrl.sv
// rof_stream_ctrl: streams a block of ROM samples into the rank_order filter and flags valid outputs
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start, abort  begin a block when idle / cancel the running block
//   base, len     first ROM address and sample count (1..2^ADDR_BITS), taken on accepted start
//   step          single-step issue enable, honoured only when ROF_STEP_EN is defined
//   rom_addr      ROM address presented during each issue cycle
//   filt_clr      one-cycle window clear before the first sample
//   filt_en       filter sample enable, aligned with the ROM data of each issued address
//   out_valid     filter result valid with a full window
//   busy, done    block in progress / one-cycle completion pulse
//
// Optional build macro ROF_STEP_EN: RUN issues only in cycles where step=1.
module rof_stream_ctrl #(
  parameter int N         = 3,
  parameter int ADDR_BITS = 8,
  parameter int ROM_LAT   = 1,
  parameter int FILT_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] base,
  input  logic [ADDR_BITS:0]   len,
  input  logic                 step,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 filt_clr,
  output logic                 filt_en,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);
  localparam int L   = ROM_LAT + FILT_LAT;
  localparam int FW  = $clog2(N + 1);
  localparam int FLW = $clog2(L + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;

  state_t             state, nxt;
  logic [ADDR_BITS:0] len_q, iss_cnt;
  logic [FW-1:0]      fill;
  logic [FLW-1:0]     fl_cnt;
  logic [ROM_LAT-1:0] en_pipe;
  logic [L-1:0]       ov_pipe;
  logic               iss, full, kill, last;

`ifdef ROF_STEP_EN
  assign iss = state == RUN && step;
`else
  assign iss = state == RUN && (step || 1'b1);
`endif

  // fill counts samples already fed into this block's window, saturating at N-1
  assign full = fill >= FW'(N - 1);
  assign kill = abort && state != IDLE;
  assign last = iss && iss_cnt + 1'b1 == len_q;

  // each delay stage is a flop, so both strobes are registered outputs
  assign filt_en   = en_pipe[ROM_LAT-1];
  assign out_valid = ov_pipe[L-1];

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && len != '0 ? CLEAR : IDLE;
      CLEAR:   nxt = RUN;
      RUN:     nxt = last ? FLUSH : RUN;
      FLUSH:   nxt = fl_cnt == FLW'(L - 1) ? DONE : FLUSH;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      len_q    <= '0;
      iss_cnt  <= '0;
      fill     <= '0;
      fl_cnt   <= '0;
      en_pipe  <= '0;
      ov_pipe  <= '0;
      filt_clr <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      filt_clr <= nxt == CLEAR;
      busy     <= nxt != IDLE;
      done     <= nxt == DONE;
      fl_cnt   <= state == FLUSH ? fl_cnt + 1'b1 : '0;
      if (kill) begin
        en_pipe <= '0;
        ov_pipe <= '0;
        fill    <= '0;
        iss_cnt <= '0;
      end else begin
        // delays advance every clock so stepped issues still give single-cycle strobes
        en_pipe <= ROM_LAT'({en_pipe, iss});
        ov_pipe <= L'({ov_pipe, iss && full});
        if (state == IDLE && nxt == CLEAR) begin
          rom_addr <= base;
          len_q    <= len;
          iss_cnt  <= '0;
          fill     <= '0;
        end else if (iss) begin
          rom_addr <= rom_addr + 1'b1;
          iss_cnt  <= iss_cnt + 1'b1;
          fill     <= full ? fill : fill + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rof_stream_ctrl.sv
// tb_rof_stream_ctrl: directed bench with a cycle-timeline model of the stream sequencer
module tb_rof_stream_ctrl;
  localparam int N  = 3;
  localparam int AB = 8;
  localparam int RL = 1;
  localparam int FL = 1;
  localparam int TL = 1024;

  logic          clk = 1'b0;
  logic          rst, start, abort, step;
  logic [AB-1:0] base;
  logic [AB:0]   len;
  logic [AB-1:0] rom_addr;
  logic          filt_clr, filt_en, out_valid, busy, done;

  rof_stream_ctrl #(.N(N), .ADDR_BITS(AB), .ROM_LAT(RL), .FILT_LAT(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .len(len), .step(step),
    .rom_addr(rom_addr), .filt_clr(filt_clr), .filt_en(filt_en), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef ROF_STEP_EN
  wire step_ok = step;
`else
  wire step_ok = 1'b1;
`endif

  // model: block phase plus a timeline of future strobe events indexed by cycle number
  localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_FL = 3, P_DONE = 4;
  int ph = P_IDLE, m_addr = 0, m_len = 0, m_iss = 0, m_fl = 0, cyc = 0;
  bit fe_t[0:TL-1];
  bit ov_t[0:TL-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE;
      m_addr = 0;
      for (int j = 0; j < TL; j++) begin
        fe_t[j] = 1'b0;
        ov_t[j] = 1'b0;
      end
    end else begin
      if (ph == P_IDLE) begin
        if (start && len != 0) begin
          ph = P_CLR; m_addr = base; m_len = len; m_iss = 0;
        end
      end else if (abort) begin
        ph = P_IDLE;
        for (int j = 1; j <= RL + FL + 1; j++) begin
          fe_t[(cyc + j) % TL] = 1'b0;
          ov_t[(cyc + j) % TL] = 1'b0;
        end
      end else if (ph == P_CLR) ph = P_RUN;
      else if (ph == P_RUN) begin
        if (step_ok) begin
          fe_t[(cyc + RL) % TL] = 1'b1;
          if (m_iss >= N - 1) ov_t[(cyc + RL + FL) % TL] = 1'b1;
          m_iss++;
          m_addr = (m_addr + 1) % (1 << AB);
          if (m_iss == m_len) begin ph = P_FL; m_fl = 0; end
        end
      end else if (ph == P_FL) begin
        m_fl++;
        if (m_fl == RL + FL) ph = P_DONE;
      end else ph = P_IDLE;
      fe_t[cyc % TL] = 1'b0;
      ov_t[cyc % TL] = 1'b0;
      cyc++;
    end
  end

  int n_chk = 0, n_pass = 0;
  int n_fe = 0, n_ov = 0, n_done = 0, n_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    if (!rst) begin
      chk("rom_addr", rom_addr, m_addr);
      chk("filt_clr", filt_clr, ph == P_CLR);
      chk("filt_en", filt_en, fe_t[cyc % TL]);
      chk("out_valid", out_valid, ov_t[cyc % TL]);
      chk("busy", busy, ph != P_IDLE);
      chk("done", done, ph == P_DONE);
      n_fe += filt_en; n_ov += out_valid; n_done += done; n_busy += busy;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
      @(posedge clk);
    end
    #1;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (busy && i < max) begin tick(1); i++; end
    chk("idle_timeout", busy, 0);
    tick(1);
  endtask

  task automatic go(input int b, input int l);
    base = AB'(b); len = (AB + 1)'(l); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int f0, o0, d0, b0;
  task automatic snap();
    f0 = n_fe; o0 = n_ov; d0 = n_done; b0 = n_busy;
  endtask

  task automatic deltas(input string tag, input int fe, input int ov, input int dn);
    chk({tag, "_filt_en_count"}, n_fe - f0, fe);
    chk({tag, "_out_valid_count"}, n_ov - o0, ov);
    chk({tag, "_done_count"}, n_done - d0, dn);
  endtask

  logic [AB-1:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 8'hFE; wrap_seq[1] = 8'hFF; wrap_seq[2] = 8'h00; wrap_seq[3] = 8'h01;
    rst = 1'b1; start = 1'b0; abort = 1'b0; step = 1'b0; base = '0; len = '0;
    tick(2);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_filt_en", filt_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_filt_clr", filt_clr, 0);
    rst = 1'b0;
    tick(2);

    snap();
    go(8'h10, 5);
    chk("basic_clr_after_start", filt_clr, 1);
    chk("basic_first_addr", rom_addr, 8'h10);
    wait_idle(60);
    deltas("basic", 5, 3, 1);
    chk("basic_end_addr", rom_addr, 8'h15);

    snap();
    go(8'hFE, 4);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("wrap_addr_seq", rom_addr, wrap_seq[i]);
    end
    wait_idle(60);
    deltas("wrap", 4, 2, 1);

    snap();
    go(8'h05, 2);
    wait_idle(60);
    deltas("short", 2, 0, 1);

    snap();
    go(8'h05, 0);
    tick(4);
    chk("len0_busy_cycles", n_busy - b0, 0);
    chk("len0_done_count", n_done - d0, 0);

    snap();
    go(8'h20, 10);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy_drop", busy, 0);
    chk("abort_addr_hold", rom_addr, 8'h23);
    tick(6);
    deltas("abort", 3, 0, 0);
    snap();
    go(8'h30, 3);
    wait_idle(60);
    deltas("after_abort", 3, 1, 1);

    snap();
    base = 8'h40; len = 4; start = 1'b1;
    for (int i = 0; i < 40 && !done; i++) tick(1);
    chk("held_start_done_seen", done, 1);
    start = 1'b0;
    tick(4);
    deltas("held_start", 4, 2, 1);
    chk("held_start_idle", busy, 0);

    snap();
    abort = 1'b1;
    go(8'h48, 3);
    abort = 1'b0;
    chk("start_beats_abort", filt_clr, 1);
    wait_idle(60);
    deltas("start_abort", 3, 1, 1);

`ifdef ROF_STEP_EN
    snap();
    go(8'h60, 3);
    for (int i = 0; i < 24; i++) begin
      step = (i % 4 == 3);
      tick(1);
    end
    step = 1'b0;
    wait_idle(60);
    deltas("step", 3, 1, 1);
`endif

    snap();
    go(8'h50, 10);
    tick(3);
    chk("pre_rst_filt_en", filt_en, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rom_addr", rom_addr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_filt_en", filt_en, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_filt_clr", filt_clr, 0);
    chk("async_rst_done", done, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post_rst_done_count", n_done - d0, 0);
    chk("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
